regfile_arbiter: RTL

Two-requester round-robin arbiter sharing the 16 × 16-bit register file (`my_regfile`) between two clients, e.g. the instruction-decode read path and a debug/load port. Each cycle it grants at most one request and drives the file's read address (`n1`), reading the combinational `rd1`, or its write port. Read data is registered and returned with a one-cycle valid pulse. An optional lock lets a client hold consecutive grants for a bounded burst.

---
 rtl/regfile_arbiter_if.sv | 41 ++++
 rtl/regfile_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter_if.sv
// Bundle between the two register-file clients, the arbiter and the register file ports.
// slave = arbiter side, master = client/register-file side.
interface regfile_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic          a_req;
   logic          b_req;
   logic          a_we;
   logic          b_we;
   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] a_wdata;
   logic [DW-1:0] b_wdata;
   logic          a_lock;
   logic          b_lock;
   logic          a_gnt;
   logic          b_gnt;
   logic          a_rvalid;
   logic          b_rvalid;
   logic [DW-1:0] rdata;
   logic [AW-1:0] rf_n1;
   logic [DW-1:0] rf_rd1;
   logic          rf_we;
   logic [AW-1:0] rf_wn;
   logic [DW-1:0] rf_wd;

   modport slave (
      input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
      input  a_lock, b_lock, rf_rd1,
      output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata,
      output rf_n1, rf_we, rf_wn, rf_wd
   );

   modport master (
      output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
      output a_lock, b_lock, rf_rd1,
      input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata,
      input  rf_n1, rf_we, rf_wn, rf_wd
   );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-client round-robin arbiter in front of a 16x16 register file, with bounded lock bursts.
// Optional per-client grant counters when REGFILE_ARB_STATS_EN is defined.
module regfile_arbiter #(
   parameter int DW        = 16,
   parameter int AW        = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_arbiter_if.slave    bus
`ifdef REGFILE_ARB_STATS_EN
   ,
   output logic [7:0]          a_gnt_cnt,
   output logic [7:0]          b_gnt_cnt
`endif
);

   typedef enum logic {
      CL_A = 1'b0,
      CL_B = 1'b1
   } client_t;

   localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

   client_t       r_last;
   client_t       w_last_nxt;
   client_t       w_gnt_cl;
   logic [3:0]    r_burst;
   logic [3:0]    w_burst_nxt;
   logic          w_keep;
   logic          w_gnt_a;
   logic          w_gnt_b;
   logic          w_any;
   logic          w_lock_sel;
   logic          w_we_sel;
   logic [AW-1:0] w_addr_sel;
   logic [DW-1:0] w_wdata_sel;
   logic          r_a_rvalid_p1;
   logic          r_b_rvalid_p1;
   logic [DW-1:0] r_rdata_p1;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   // Grant decision; held at zero while reset is asserted so nothing reaches the file.
   always_comb begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
      w_keep  = ((r_last == CL_A) ? bus.a_lock : bus.b_lock) && (r_burst < LP_MAX_BURST);
      if (rst_n) begin
         if (bus.a_req && !bus.b_req) begin
            w_gnt_a = 1'b1;
         end else if (!bus.a_req && bus.b_req) begin
            w_gnt_b = 1'b1;
         end else if (bus.a_req && bus.b_req) begin
            if (r_last == CL_A) begin
               w_gnt_a = w_keep;
               w_gnt_b = !w_keep;
            end else begin
               w_gnt_b = w_keep;
               w_gnt_a = !w_keep;
            end
         end
      end
   end

   assign w_any       = w_gnt_a | w_gnt_b;
   assign w_gnt_cl    = w_gnt_b ? CL_B : CL_A;
   assign w_lock_sel  = w_gnt_b ? bus.b_lock  : bus.a_lock;
   assign w_we_sel    = w_gnt_b ? bus.b_we    : bus.a_we;
   assign w_addr_sel  = w_gnt_b ? bus.b_addr  : bus.a_addr;
   assign w_wdata_sel = w_gnt_b ? bus.b_wdata : bus.a_wdata;

   // An unlocked grant clears the burst so the next conflict alternates.
   always_comb begin
      w_last_nxt  = r_last;
      w_burst_nxt = r_burst;
      if (w_any) begin
         if (w_gnt_cl == r_last) begin
            w_burst_nxt = sat_inc(r_burst);
         end else begin
            w_last_nxt  = w_gnt_cl;
            w_burst_nxt = 4'd1;
         end
         if (!w_lock_sel) begin
            w_burst_nxt = 4'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last  <= CL_B;
         r_burst <= 4'd0;
      end else begin
         r_last  <= w_last_nxt;
         r_burst <= w_burst_nxt;
      end
   end

   // Read data stage: capture the file's combinational output at the grant edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_rvalid_p1 <= 1'b0;
         r_b_rvalid_p1 <= 1'b0;
         r_rdata_p1    <= '0;
      end else begin
         r_a_rvalid_p1 <= w_gnt_a & ~bus.a_we;
         r_b_rvalid_p1 <= w_gnt_b & ~bus.b_we;
         if (w_any && !w_we_sel) begin
            r_rdata_p1 <= bus.rf_rd1;
         end
      end
   end

   assign bus.a_gnt    = w_gnt_a;
   assign bus.b_gnt    = w_gnt_b;
   assign bus.rf_n1    = w_addr_sel;
   assign bus.rf_wn    = w_addr_sel;
   assign bus.rf_wd    = w_wdata_sel;
   assign bus.rf_we    = w_any & w_we_sel;
   assign bus.a_rvalid = r_a_rvalid_p1;
   assign bus.b_rvalid = r_b_rvalid_p1;
   assign bus.rdata    = r_rdata_p1;

`ifdef REGFILE_ARB_STATS_EN
   logic [7:0] r_a_gnt_cnt;
   logic [7:0] r_b_gnt_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_gnt_cnt <= 8'd0;
         r_b_gnt_cnt <= 8'd0;
      end else begin
         if (w_gnt_a) r_a_gnt_cnt <= r_a_gnt_cnt + 8'd1;
         if (w_gnt_b) r_b_gnt_cnt <= r_b_gnt_cnt + 8'd1;
      end
   end

   assign a_gnt_cnt = r_a_gnt_cnt;
   assign b_gnt_cnt = r_b_gnt_cnt;
`endif

endmodule
